sync_fifo_flags: RTL
====================

// Module: sync_fifo_flags
// PURPOSE
//  Single-clock, parametrised FIFO. Owns the storage and the read/write pointers.
//  Produces full, empty, almost-full and almost-empty flags, an occupancy count and
//  sticky overflow/underflow errors. Drop-in buffer between same-clock producer and
//  consumer stages; successor to the split mem-only FIFO with external flag logic.
// PARAMETERS
//  DATA_WIDTH  9   data word width, bits (>=1)
//  ADDR_WIDTH  4   log2(depth); DEPTH = 2**ADDR_WIDTH (>=1, so DEPTH>=2)
//  AF_THRESH   DEPTH-2  ALMOST_FULL asserts when COUNT >= AF_THRESH (1..DEPTH)
//  AE_THRESH   1   ALMOST_EMPTY asserts when COUNT <= AE_THRESH (0..DEPTH-1)
// PORTS
//  CLK           in   1             rising-edge clock, sole clock domain
//  RST_N         in   1             asynchronous, active-low reset
//  I_DATA        in   DATA_WIDTH    write data
//  W_EN          in   1             write request
//  R_EN          in   1             read request
//  CLR_ERR       in   1             clear sticky OVERFLOW/UNDERFLOW
//  O_DATA        out  DATA_WIDTH    read data
//  O_VALID       out  1             O_DATA holds a popped/head word
//  FULL          out  1             COUNT == DEPTH
//  EMPTY         out  1             COUNT == 0
//  ALMOST_FULL   out  1             COUNT >= AF_THRESH
//  ALMOST_EMPTY  out  1             COUNT <= AE_THRESH
//  COUNT         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  OVERFLOW      out  1             sticky: write attempted while FULL
//  UNDERFLOW     out  1             sticky: read attempted while EMPTY
// BEHAVIOUR
//  - Reset (RST_N low, async assert):
//    wptr=rptr=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0,
//    O_DATA=0, O_VALID=0, OVERFLOW=0, UNDERFLOW=0. Storage array is not reset.
//    Reset mid-operation discards all contents.
//  - Pointers are ADDR_WIDTH+1 bits; MSB is the wrap bit. Address = low ADDR_WIDTH bits.
//    COUNT = wptr - rptr (modulo 2**(ADDR_WIDTH+1)). All flags decode from the
//    registered pointers only; no combinational path from W_EN/R_EN to any flag.
//  - Write accepted iff W_EN && !FULL: mem[wptr] <= I_DATA, wptr++.
//    W_EN && FULL: nothing stored; OVERFLOW <= 1.
//  - Read accepted iff R_EN && !EMPTY: rptr++.
//    R_EN && EMPTY: no pop; UNDERFLOW <= 1.
//  - Simultaneous accepted read+write: COUNT unchanged, both pointers advance.
//    FULL: read accepted, write rejected. EMPTY: write accepted, read rejected.
//  - Wrap: pointers roll 2**(ADDR_WIDTH+1)-1 -> 0 with no special handling.
//  - CLR_ERR clears both sticky bits next edge. A new error in the same cycle wins (bit stays 1).
//  - Read data (default, macro undefined): registered, 1-cycle latency.
//    After an accepted read at edge N, O_DATA = popped word and O_VALID=1 after
//    edge N+1-1 (i.e. updated at edge N), for one cycle. With no accepted read,
//    O_VALID=0 and O_DATA holds its last value (never X).
//  - Elaboration $error if AF_THRESH or AE_THRESH is out of range.
// CONFIGURATION
//  SYNC_FIFO_FWFT_EN defined: first-word-fall-through.
//    O_DATA = mem[rptr] combinationally, O_VALID = !EMPTY, R_EN acks the head word
//    (0-cycle read latency). A word written into an empty FIFO appears 1 cycle after
//    its write edge. O_DATA is a don't-care while O_VALID=0.
//  Undefined: registered read mode as above.
//  Flags, COUNT and error behaviour are identical in both modes.
// STRUCTURE
//  - Package sync_fifo_pkg:
//    - localparam function for DEPTH from ADDR_WIDTH;
//    - typedef ptr_t (ADDR_WIDTH+1-bit, via parametrised helper);
//    - enum err_e {ERR_NONE, ERR_OVF, ERR_UDF} for bench/scoreboard use.
//  - Sub-module fifo_ram: 1W/1R register array. Write is synchronous; the read port
//    is combinational. The top level applies the output register or FWFT bypass.
//  - Pointer/flag logic stays in the top level (no separate FSM; state = pointer pair).
// TESTING
//  - Reset: hold RST_N=0 with W_EN=1 -> all outputs at reset values, COUNT=0, EMPTY=1.
//  - Fill: ADDR_WIDTH=4, write 0x000..0x00F -> COUNT=16, FULL=1 after 16th edge.
//    ALMOST_FULL first high at COUNT=14. The 17th write sets OVERFLOW; contents unchanged.
//  - Drain: read 16 times -> data 0x000..0x00F in order (1-cycle latency, O_VALID
//    pulses). EMPTY=1 after the last pop. An extra R_EN sets UNDERFLOW; CLR_ERR clears it.
//  - Wrap/simultaneous: hold COUNT=8, issue 40 cycles of W_EN=R_EN=1 -> COUNT stays 8,
//    pointers wrap, and the output sequence equals the input sequence.
//  - Boundary: FULL with W_EN=R_EN=1 -> COUNT 16->15, OVERFLOW=1.
//    EMPTY with both -> COUNT 0->1, UNDERFLOW=1.
//  - With SYNC_FIFO_FWFT_EN: write 0x1A5 into empty -> next cycle O_VALID=1,
//    O_DATA=0x1A5 before any R_EN. R_EN pops it; O_VALID=0 next cycle.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and error codes for the sync_fifo_flags block.
package sync_fifo_pkg;

  function automatic int fifo_depth(input int addr_w);
    return 2 ** addr_w;
  endfunction

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UDF  = 2'd2
  } err_e;

endpackage

// File: rtl/sync_fifo_ram.sv
// fifo_ram: 1W/1R register array, synchronous write, combinational read.
module fifo_ram #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] I_DATA,
  input  logic                  W_EN,
  input  logic                  R_EN,
  input  logic                  CLR_ERR,
  output logic [DATA_WIDTH-1:0] O_DATA,
  output logic                  O_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  typedef logic [ptr_w(ADDR_WIDTH)-1:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t AF_P    = ptr_t'(AF_THRESH);
  localparam ptr_t AE_P    = ptr_t'(AE_THRESH);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_bad
    $error("sync_fifo_flags: AF_THRESH %0d outside 1..%0d", AF_THRESH, DEPTH);
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_bad
    $error("sync_fifo_flags: AE_THRESH %0d outside 0..%0d", AE_THRESH, DEPTH - 1);
  end

  ptr_t                  wptr, rptr, count;
  logic                  wr_acc, rd_acc;
  logic                  ovf_q, udf_q;
  logic [DATA_WIDTH-1:0] rd_data;

  // Flags decode purely from the registered pointer pair.
  assign count        = wptr - rptr;
  assign COUNT        = count;
  assign FULL         = (count == DEPTH_P);
  assign EMPTY        = (count == '0);
  assign ALMOST_FULL  = (count >= AF_P);
  assign ALMOST_EMPTY = (count <= AE_P);
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;

  assign wr_acc = W_EN && !FULL;
  assign rd_acc = R_EN && !EMPTY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ptr_t'(1);
      if (rd_acc) rptr <= rptr + ptr_t'(1);
      // A fresh error in the clearing cycle keeps the bit set.
      if (W_EN && FULL)  ovf_q <= 1'b1;
      else if (CLR_ERR)  ovf_q <= 1'b0;
      if (R_EN && EMPTY) udf_q <= 1'b1;
      else if (CLR_ERR)  udf_q <= 1'b0;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (CLK),
    .we    (wr_acc),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (I_DATA),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign O_DATA  = rd_data;
  assign O_VALID = !EMPTY;
`else
  logic [DATA_WIDTH-1:0] o_data_q;
  logic                  o_valid_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      o_valid_q <= rd_acc;
      if (rd_acc) o_data_q <= rd_data;
    end
  end

  assign O_DATA  = o_data_q;
  assign O_VALID = o_valid_q;
`endif

endmodule
